// File: rtl/riscv_uc_pkg.sv
// Shared types and encodings for the riscv_uc multicycle control unit.
// Holds the state and instruction-class encodings, datapath select values and the opcode classifier.
package riscv_uc_pkg;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_IDLE   = 4'd1,
    ST_FETCH  = 4'd2,
    ST_DECODE = 4'd3,
    ST_EXEC   = 4'd4,
    ST_MEM    = 4'd5,
    ST_WB     = 4'd6,
    ST_BR     = 4'd7,
    ST_TRAP   = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_I      = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_ILL    = 3'd5
  } cls_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] M1_RS2   = 2'd0;
  localparam logic [1:0] M1_IMM   = 2'd1;
  localparam logic [1:0] M2_MEM   = 2'd0;
  localparam logic [1:0] M2_ALU   = 2'd1;
  localparam logic [1:0] M3_PC1   = 2'd0;
  localparam logic [1:0] M3_PCIMM = 2'd1;
  localparam logic [1:0] M4_ALU   = 2'd0;
  localparam logic [1:0] M4_RS2   = 2'd1;

  typedef struct packed {
    logic       pc_load;
    logic       pc_reset;
    logic       mem_re;
    logic       mem_we;
    logic       rf_we;
    logic [1:0] alu_op;
    logic [1:0] mux_1;
    logic [1:0] mux_2;
    logic [1:0] mux_3;
    logic [1:0] mux_4;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{
    pc_load: 1'b0, pc_reset: 1'b0, mem_re: 1'b0, mem_we: 1'b0, rf_we: 1'b0,
    alu_op: 2'b00, mux_1: 2'b00, mux_2: 2'b00, mux_3: 2'b00, mux_4: 2'b00,
    illegal: 1'b0
  };

  function automatic cls_e classify(input logic [6:0] opc);
    cls_e cls;
    case (opc)
      OPC_R:      cls = CLS_R;
      OPC_I:      cls = CLS_I;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_BRANCH: cls = CLS_BRANCH;
      default:    cls = CLS_ILL;
    endcase
    return cls;
  endfunction

  // ALU operation and B-operand select used in EXEC (and held through R/I writeback).
  function automatic logic [1:0] exec_alu_op(input cls_e cls);
    logic [1:0] op;
    case (cls)
      CLS_R, CLS_I:         op = ALU_FUNCT;
      CLS_LOAD, CLS_STORE:  op = ALU_ADD;
      CLS_BRANCH:           op = ALU_BR;
      default:              op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [1:0] exec_mux_1(input cls_e cls);
    logic [1:0] sel;
    case (cls)
      CLS_I, CLS_LOAD, CLS_STORE: sel = M1_IMM;
      CLS_R, CLS_BRANCH:          sel = M1_RS2;
      default:                    sel = M1_RS2;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/riscv_uc.sv
// Multicycle control FSM sequencing the riscv_dp datapath, with run/stop and retire counter.
// Outputs are decoded from the next state and registered; only the BR next-PC select follows branch live.
module riscv_uc
  import riscv_uc_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [6:0]           opcode,
  input  logic                 branch,
  output logic                 pc_load,
  output logic                 pc_reset,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic                 reg_file_write,
  output logic [1:0]           alu_op,
  output logic [1:0]           select_mux_1,
  output logic [1:0]           select_mux_2,
  output logic [1:0]           select_mux_3,
  output logic [1:0]           select_mux_4,
  output logic [3:0]           state,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  localparam ctrl_t CTRL_RST = '{
    pc_load: 1'b0, pc_reset: 1'b1, mem_re: 1'b0, mem_we: 1'b0, rf_we: 1'b0,
    alu_op: 2'b00, mux_1: 2'b00, mux_2: 2'b00, mux_3: 2'b00, mux_4: 2'b00,
    illegal: 1'b0
  };

  state_e               state_q, state_d;
  cls_e                 cls_q, cls_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;

  // Next-state logic; the instruction class is captured only while in DECODE.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    case (state_q)
      ST_RST:   state_d = ST_IDLE;
      ST_IDLE:  state_d = run ? ST_FETCH : ST_IDLE;
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        cls_d = classify(opcode);
        if (cls_d == CLS_ILL) begin
          state_d = ST_TRAP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_R, CLS_I:        state_d = ST_WB;
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH:          state_d = ST_BR;
          default:             state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (cls_q == CLS_STORE) begin
          state_d = run ? ST_FETCH : ST_IDLE;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB:   state_d = run ? ST_FETCH : ST_IDLE;
      ST_BR:   state_d = run ? ST_FETCH : ST_IDLE;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_RST;
    endcase
  end

  // Datapath controls for the state being entered, so they can be registered.
  always_comb begin
    ctrl_d = CTRL_NONE;
    case (state_d)
      ST_RST: ctrl_d = CTRL_RST;
      ST_IDLE, ST_FETCH, ST_DECODE: ctrl_d = CTRL_NONE;
      ST_EXEC: begin
        ctrl_d.alu_op = exec_alu_op(cls_d);
        ctrl_d.mux_1  = exec_mux_1(cls_d);
      end
      ST_MEM: begin
        ctrl_d.alu_op = ALU_ADD;
        ctrl_d.mux_1  = M1_IMM;
        if (cls_d == CLS_STORE) begin
          ctrl_d.mem_we  = 1'b1;
          ctrl_d.mux_4   = M4_RS2;
          ctrl_d.pc_load = 1'b1;
          ctrl_d.mux_3   = M3_PC1;
        end else begin
          ctrl_d.mem_re  = 1'b1;
        end
      end
      ST_WB: begin
        ctrl_d.rf_we   = 1'b1;
        ctrl_d.pc_load = 1'b1;
        ctrl_d.mux_3   = M3_PC1;
        if (cls_d == CLS_LOAD) begin
          ctrl_d.mux_2  = M2_MEM;
          ctrl_d.mem_re = 1'b1;
          ctrl_d.mux_1  = M1_IMM;
          ctrl_d.alu_op = ALU_ADD;
        end else begin
          ctrl_d.mux_2  = M2_ALU;
          ctrl_d.alu_op = exec_alu_op(cls_d);
          ctrl_d.mux_1  = exec_mux_1(cls_d);
        end
      end
      ST_BR: begin
        ctrl_d.alu_op  = ALU_BR;
        ctrl_d.mux_1   = M1_RS2;
        ctrl_d.pc_load = 1'b1;
      end
      ST_TRAP: ctrl_d.illegal = 1'b1;
      default: ctrl_d = CTRL_NONE;
    endcase
  end

  // A retiring cycle is exactly one with pc_load asserted.
  always_comb begin
    if (ctrl_q.pc_load) begin
      instret_d = instret_q + INSTRET_W'(1);
    end else begin
      instret_d = instret_q;
    end
  end

  // State, class, control and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RST;
      cls_q     <= CLS_ILL;
      ctrl_q    <= CTRL_RST;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      ctrl_q    <= ctrl_d;
      instret_q <= instret_d;
    end
  end

  assign pc_load        = ctrl_q.pc_load;
  assign pc_reset       = ctrl_q.pc_reset;
  assign mem_re         = ctrl_q.mem_re;
  assign mem_we         = ctrl_q.mem_we;
  assign reg_file_write = ctrl_q.rf_we;
  assign alu_op         = ctrl_q.alu_op;
  assign select_mux_1   = ctrl_q.mux_1;
  assign select_mux_2   = ctrl_q.mux_2;
  // Taken/not-taken is resolved by the datapath during BR itself.
  assign select_mux_3   = ctrl_q.mux_3 | ((state_q == ST_BR) ? {1'b0, branch} : 2'b00);
  assign select_mux_4   = ctrl_q.mux_4;
  assign illegal        = ctrl_q.illegal;
  assign state          = state_q;
  assign instret        = instret_q;

endmodule

// File: tb/tb_riscv_uc.sv
// Self-checking bench for riscv_uc: directed and randomized instruction streams checked
// against a per-class phase model of the control unit.
module tb_riscv_uc;

  localparam int W = 32;

  localparam int P_RST = 0, P_IDLE = 1, P_FETCH = 2, P_DECODE = 3, P_EXEC = 4;
  localparam int P_MEM = 5, P_WB = 6, P_BR = 7, P_TRAP = 8;
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4;

  logic         clk = 1'b0;
  logic         reset, run, branch;
  logic [6:0]   opcode;
  logic         pc_load, pc_reset, mem_re, mem_we, reg_file_write, illegal;
  logic [1:0]   alu_op, select_mux_1, select_mux_2, select_mux_3, select_mux_4;
  logic [3:0]   state;
  logic [W-1:0] instret;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] instret_m;
  bit           retire_pending;

  always #5 clk = ~clk;

  riscv_uc #(.INSTRET_W(W)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .branch(branch),
    .pc_load(pc_load), .pc_reset(pc_reset), .mem_re(mem_re), .mem_we(mem_we),
    .reg_file_write(reg_file_write), .alu_op(alu_op),
    .select_mux_1(select_mux_1), .select_mux_2(select_mux_2),
    .select_mux_3(select_mux_3), .select_mux_4(select_mux_4),
    .state(state), .illegal(illegal), .instret(instret)
  );

  function automatic logic [6:0] opc_of(input int c);
    case (c)
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_LD:    return 7'b0000011;
      C_ST:    return 7'b0100011;
      default: return 7'b1100011;
    endcase
  endfunction

  function automatic int seq_len(input int c);
    return (c == C_LD) ? 5 : 4;
  endfunction

  // Phase visited k cycles after FETCH; the last phase is the retiring one.
  function automatic int seq_phase(input int c, input int k);
    case (k)
      0: return P_FETCH;
      1: return P_DECODE;
      2: return P_EXEC;
      3: begin
        if (c == C_LD || c == C_ST) return P_MEM;
        else if (c == C_BR) return P_BR;
        else return P_WB;
      end
      default: return P_WB;
    endcase
  endfunction

  // {pc_load,pc_reset,mem_re,mem_we,rfw,alu_op,m1,m2,m3,m4,illegal}
  function automatic logic [15:0] exp_out(input int p, input int c, input logic br);
    logic pl, pr, re, we, rf, il;
    logic [1:0] alu, m1, m2, m3, m4;
    pl = 1'b0; pr = 1'b0; re = 1'b0; we = 1'b0; rf = 1'b0; il = 1'b0;
    alu = 2'd0; m1 = 2'd0; m2 = 2'd0; m3 = 2'd0; m4 = 2'd0;
    case (p)
      P_RST:  pr = 1'b1;
      P_EXEC: begin
        if (c == C_R)      begin alu = 2'b10; m1 = 2'd0; end
        else if (c == C_I) begin alu = 2'b10; m1 = 2'd1; end
        else if (c == C_BR) begin alu = 2'b01; m1 = 2'd0; end
        else               begin alu = 2'b00; m1 = 2'd1; end
      end
      P_MEM: begin
        alu = 2'b00; m1 = 2'd1;
        if (c == C_ST) begin we = 1'b1; m4 = 2'd1; pl = 1'b1; end
        else re = 1'b1;
      end
      P_WB: begin
        rf = 1'b1; pl = 1'b1;
        if (c == C_LD) begin m2 = 2'd0; re = 1'b1; m1 = 2'd1; alu = 2'b00; end
        else begin m2 = 2'd1; alu = 2'b10; m1 = (c == C_I) ? 2'd1 : 2'd0; end
      end
      P_BR:   begin alu = 2'b01; m1 = 2'd0; pl = 1'b1; m3 = {1'b0, br}; end
      P_TRAP: il = 1'b1;
      default: ;
    endcase
    return {pl, pr, re, we, rf, alu, m1, m2, m3, m4, il};
  endfunction

  task automatic check(input string tag, input int p, input int c, input logic br);
    logic [15:0] got, exp;
    got = {pc_load, pc_reset, mem_re, mem_we, reg_file_write, alu_op, select_mux_1,
           select_mux_2, select_mux_3, select_mux_4, illegal};
    exp = exp_out(p, c, br);
    n_cmp++;
    assert (state === 4'(p)) else begin
      n_bad++; $error("FAIL %s state: got %0d expected %0d", tag, state, p);
    end
    n_cmp++;
    assert (got === exp) else begin
      n_bad++; $error("FAIL %s outputs: got %b expected %b", tag, got, exp);
    end
    n_cmp++;
    assert (instret === instret_m) else begin
      n_bad++; $error("FAIL %s instret: got %0d expected %0d", tag, instret, instret_m);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (retire_pending) begin
      instret_m = instret_m + 32'd1;
      retire_pending = 1'b0;
    end
    #1;
  endtask

  // IDLE for n cycles; run is raised in the last one so the next edge fetches.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      run    = (i == n - 1);
      opcode = 7'($urandom);
      branch = 1'($urandom);
      #1;
      check("idle", P_IDLE, C_R, branch);
    end
  endtask

  // One instruction starting at FETCH; run only matters on the retiring cycle.
  task automatic do_instr(input int c, input logic br, input logic run_after,
                          input int abort_k, input bit drop_run);
    int len;
    len = seq_len(c);
    for (int k = 0; k < len; k++) begin
      tick();
      opcode = (k == 1) ? opc_of(c) : 7'($urandom);
      branch = (c == C_BR && k == len - 1) ? br : 1'($urandom);
      if (k == len - 1)            run = run_after;
      else if (drop_run && k >= 2) run = 1'b0;
      else                         run = 1'($urandom);
      reset = (k == abort_k);
      #1;
      check($sformatf("cls%0d_k%0d", c, k), seq_phase(c, k), c, branch);
      if (k == abort_k) break;
      if (k == len - 1) retire_pending = 1'b1;
    end
  endtask

  initial begin
    bit ra;
    reset = 1'b1; run = 1'b0; opcode = 7'd0; branch = 1'b0;
    instret_m = 32'd0; retire_pending = 1'b0;

    tick(); #1; check("reset0", P_RST, C_R, 1'b0);
    tick(); reset = 1'b0; #1; check("reset1", P_RST, C_R, 1'b0);
    idle_cycles(2);

    do_instr(C_R,  1'b0, 1'b1, -1, 1'b0);
    do_instr(C_LD, 1'b0, 1'b1, -1, 1'b0);
    do_instr(C_ST, 1'b0, 1'b1, -1, 1'b0);
    do_instr(C_BR, 1'b1, 1'b1, -1, 1'b0);
    do_instr(C_BR, 1'b0, 1'b1, -1, 1'b0);
    do_instr(C_I,  1'b0, 1'b1, -1, 1'b0);
    do_instr(C_R,  1'b0, 1'b0, -1, 1'b1);
    idle_cycles(3);

    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 3) != 0);
      do_instr($urandom_range(0, 4), 1'($urandom), ra, -1, 1'b0);
      if (!ra) idle_cycles($urandom_range(1, 3));
    end

    // Reset in the MEM cycle of a load must drop the access and the writeback.
    do_instr(C_LD, 1'b0, 1'b1, 3, 1'b0);
    tick(); instret_m = 32'd0; reset = 1'b0; run = 1'b0; #1;
    check("abort_rst", P_RST, C_R, 1'b0);
    idle_cycles(1);
    do_instr(C_R, 1'b0, 1'b1, -1, 1'b0);

    tick(); opcode = 7'($urandom); #1; check("trap_fetch", P_FETCH, C_R, branch);
    tick(); opcode = 7'b1111111; #1; check("trap_decode", P_DECODE, C_R, branch);
    for (int i = 0; i < 10; i++) begin
      tick();
      opcode = 7'($urandom); run = 1'($urandom); branch = 1'($urandom);
      #1;
      check($sformatf("trap_%0d", i), P_TRAP, C_R, branch);
    end
    reset = 1'b1;
    tick(); instret_m = 32'd0; reset = 1'b0; run = 1'b0; #1;
    check("trap_rst", P_RST, C_R, 1'b0);
    idle_cycles(1);
    do_instr(C_I, 1'b0, 1'b0, -1, 1'b0);
    idle_cycles(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_uc.md
Name: riscv_uc

Overview:
- Multicycle control FSM that sequences riscv_dp. It drives every datapath strobe and mux select from the opcode and branch signals returned by the datapath.
- Supported classes: R-type (0110011), I-type ALU (0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011). Any other opcode traps.
- Also provides run/stop control and a retired-instruction counter for debug.

Parameters:
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- run  input  1  1 = keep fetching; 0 = stop in IDLE after the current instruction retires
- opcode  input  7  inst_out[6:0] from the datapath
- branch  input  1  branch-taken from the datapath ALU control
- pc_load  output  1  PC register load enable
- pc_reset  output  1  PC register clear
- mem_re  output  1  data memory read enable
- mem_we  output  1  data memory write enable
- reg_file_write  output  1  register file write enable
- alu_op  output  2  00 = add (address), 01 = branch compare, 10 = funct-decoded
- select_mux_1  output  2  ALU B operand: 0 = rs2, 1 = immediate
- select_mux_2  output  2  writeback source: 0 = memory, 1 = ALU
- select_mux_3  output  2  next PC: 0 = PC+1, 1 = PC+imm
- select_mux_4  output  2  store data: 0 = ALU, 1 = rs2
- state  output  4  current state, for debug
- illegal  output  1  high while in TRAP
- instret  output  INSTRET_W  count of retired instructions

Behaviour:
- States (4-bit encoding):
  - RST=0, IDLE=1, FETCH=2, DECODE=3, EXEC=4, MEM=5, WB=6, BR=7, TRAP=8.
- Reset:
  - reset=1 at an edge forces RST, from any state including mid-instruction.
  - In RST: pc_reset=1, instret=0, all other strobes 0, all selects 0, alu_op=00, illegal=0.
  - Next state is IDLE. pc_reset is high only in RST.
- Default outputs: every strobe is 0 and every select/alu_op is 00 unless listed below for the current state.
- Transitions and outputs:
  - IDLE: go to FETCH if run=1, else stay.
  - FETCH: synchronous instruction memory read cycle. Always go to DECODE.
  - DECODE: register opcode into an internal class register.
    - Supported class -> EXEC.
    - Unsupported opcode -> TRAP.
  - EXEC, outputs by class:
    - R: alu_op=10, mux_1=0.
    - I: alu_op=10, mux_1=1.
    - LOAD/STORE: alu_op=00, mux_1=1.
    - BRANCH: alu_op=01, mux_1=0.
  - EXEC next state:
    - R/I -> WB
    - LOAD/STORE -> MEM
    - BRANCH -> BR
  - MEM: mux_1=1 and alu_op=00 held so the address stays stable.
    - LOAD: mem_re=1, next WB.
    - STORE: mem_we=1, mux_4=1, pc_load=1, mux_3=0; instruction retires; next FETCH if run=1, else IDLE.
  - WB: reg_file_write=1, pc_load=1, mux_3=0.
    - R/I: mux_2=1, and the EXEC alu_op/mux_1 are held.
    - LOAD: mux_2=0, mem_re=1, mux_1=1, alu_op=00.
    - Instruction retires; next FETCH if run=1, else IDLE.
  - BR: alu_op=01, mux_1=0, pc_load=1, mux_3={1'b0, branch}. This is the only Mealy output. Instruction retires; next FETCH/IDLE on run.
  - TRAP: illegal=1, no strobes. Leaves only via reset.
- Latency, FETCH to retire inclusive:
  - R / I / STORE / BRANCH: 4 cycles.
  - LOAD: 5 cycles.
- instret:
  - Increments by 1 on each retiring edge (pc_load=1).
  - Wraps modulo 2^INSTRET_W.
  - Does not count in TRAP.
- run:
  - Sampled only in IDLE and on retiring cycles.
  - Deasserting run mid-instruction never aborts it.
- Opcode handling:
  - The class is latched in DECODE, so opcode changes after DECODE are ignored.
  - The opcode value is only meaningful in DECODE.
- Selects are 2 bits wide; bit 1 is always 0.

Decomposition:
- Package riscv_uc_pkg holds:
  - state enum;
  - opcode localparams OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH;
  - ALU_ADD / ALU_BR / ALU_FUNCT encodings;
  - mux select constants.
- Single module with no sub-module. An optional combinational opcode classifier function lives in the package.

Test Plan:
- Reset then run=1, opcode=0110011: states 0,1,2,3,4,6,2. WB has reg_file_write=1, mux_2=1, pc_load=1. instret goes 0->1.
- LOAD (0000011): EXEC mux_1=1, alu_op=00. MEM mem_re=1. WB mux_2=0, reg_file_write=1, pc_load=1. Total 5 cycles.
- STORE (0100011): MEM has mem_we=1, mux_4=1, pc_load=1, reg_file_write=0. Total 4 cycles.
- BRANCH (1100011):
  - branch=1 in BR -> mux_3=01, pc_load=1.
  - Repeat with branch=0 -> mux_3=00.
  - EXEC alu_op=01 in both cases.
- Opcode 1111111 in DECODE -> TRAP next cycle, illegal=1, no strobes for 10 cycles. reset=1 -> RST, pc_reset=1, illegal=0.
- run=0 during the EXEC of an R-type: the instruction completes WB, then IDLE holds. reset asserted in MEM of a LOAD -> RST next cycle, mem_re=0, no register write.
